// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and sizing helper for the parameterised synchronous FIFO.
package param_sync_fifo_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_DEPTH    = 16;
   localparam int DEF_AE_LEVEL = 2;

   // Occupancy counter needs one extra bit so that num can hold DEPTH itself.
   function automatic int num_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// fifo_mem_2p: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered flags and sticky error bits.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered-read mode.
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AE_LEVEL = DEF_AE_LEVEL,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             in,
   input  logic                         pop,
   output logic [WIDTH-1:0]             out,
   output logic                         empty,
   output logic                         almostempty,
   output logic                         full,
   output logic                         almostfull,
   output logic [num_width(DEPTH)-1:0]  num,
   output logic                         overflow,
   output logic                         underflow,
   input  logic                         clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = num_width(DEPTH);
   localparam logic [NW-1:0] FULL_N = NW'(DEPTH);
   localparam logic [NW-1:0] AE_N   = NW'(AE_LEVEL);
   localparam logic [NW-1:0] AF_N   = NW'(AF_LEVEL);

   logic [AW-1:0]    wptr, rptr;
   logic [WIDTH-1:0] rdata;
   logic             push_ok, pop_ok, ovf_set, unf_set;
   logic [NW-1:0]    num_nxt;

   // Handshake: push is taken when not full or when a pop frees a slot on the
   // same edge; pop is taken when not empty; flush overrides both.
   always_comb begin
      push_ok = push && (!full || pop) && !flush;
      pop_ok  = pop && !empty && !flush;
      ovf_set = push && !pop && full && !flush;
      unf_set = pop && empty && !flush;
      num_nxt = num;
      if (flush)                    num_nxt = '0;
      else if (push_ok && !pop_ok)  num_nxt = num + 1'b1;
      else if (pop_ok && !push_ok)  num_nxt = num - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         num         <= '0;
         empty       <= 1'b1;
         almostempty <= 1'b1;
         full        <= 1'b0;
         almostfull  <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
         end
         num         <= num_nxt;
         // Flags derive from the next count so they agree with num every cycle.
         empty       <= (num_nxt == '0);
         almostempty <= (num_nxt <= AE_N);
         full        <= (num_nxt == FULL_N);
         almostfull  <= (num_nxt >= AF_N);
         overflow    <= ovf_set | (overflow & ~clr_err);
         underflow   <= unf_set | (underflow & ~clr_err);
      end
   end

   fifo_mem_2p #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wptr),
      .wdata (in),
      .raddr (rptr),
      .rdata (rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign out = empty ? '0 : rdata;
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       out <= '0;
      else if (pop_ok) out <= rdata;
   end
`endif

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, range 1..256.
REQ-002 Parameter DEPTH, default 16: number of storage entries, power of two, range 4..1024.
REQ-003 Parameter AE_LEVEL, default 2: almostempty asserts when num <= AE_LEVEL.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almostfull asserts when num >= AF_LEVEL.
REQ-005 The port list SHALL be exactly, in this order:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents.
- push  input  1  write request.
- in  input  WIDTH  write data.
- pop  input  1  read request.
- out  output  WIDTH  read data.
- empty  output  1  num == 0.
- almostempty  output  1  num <= AE_LEVEL.
- full  output  1  num == DEPTH.
- almostfull  output  1  num >= AF_LEVEL.
- num  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set by push rejected while full.
- underflow  output  1  sticky; set by pop rejected while empty.
- clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-006 A push is accepted when push=1 and (full=0 or pop=1); in is written at the write pointer, and the write pointer advances modulo DEPTH.
REQ-007 A pop is accepted when pop=1 and empty=0; the read pointer advances modulo DEPTH.
REQ-008 num SHALL update in the same edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-009 Full with push=1 and pop=1: both accepted, num stays DEPTH, overflow not set.
REQ-010 Empty with push=1 and pop=1: push accepted, pop rejected, num becomes 1, underflow set.
REQ-011 push=1, pop=0 while full: data dropped, contents unchanged, overflow set to 1 on that edge.
REQ-012 pop=1 while empty (and not REQ-010): no state change except underflow set to 1.
REQ-013 Flags empty, almostempty, full, almostfull SHALL be registered and consistent with num in the same cycle.
REQ-014 flush=1: pointers and num cleared on that edge; push and pop in that cycle are ignored; overflow/underflow are not changed.
REQ-015 clr_err=1 clears overflow and underflow; a same-cycle set event takes priority over the clear.
REQ-016 Pointer wrap-around SHALL be seamless; FIFO order holds across any number of wraps.

Reset
REQ-017 On reset=1, the block SHALL immediately clear pointers, num, overflow, underflow and out to 0, and set empty=1, almostempty=1, full=0, almostfull=0.
REQ-018 Reset asserted mid-operation discards all contents; storage RAM need not be cleared.

Configuration
REQ-019 With SYNC_FIFO_FWFT_EN undefined (registered mode): out loads the head word on the edge of an accepted pop (1-cycle latency) and otherwise holds its value.
REQ-020 With SYNC_FIFO_FWFT_EN defined (first-word-fall-through): out shows the head word whenever empty=0, and a pop advances to the next word; out is don't-care while empty.

Structure
REQ-021 Package param_sync_fifo_pkg SHALL hold the default parameter constants and a function returning the num width.
REQ-022 Storage SHALL be a sub-module fifo_mem_2p: 1 write port, 1 read port, synchronous write, DEPTH x WIDTH, no reset.

Verification
REQ-023 Reset, then push 0x0001..0x0010 (16 words) -> full=1 and num=16 after the 16th edge, with almostfull=1 from num=14.
REQ-024 From full, push 0xBEEF with pop=0 -> overflow=1, num=16; pop all 16 -> words 0x0001..0x0010 in order, then empty=1.
REQ-025 With the FIFO empty, pop=1 -> underflow=1; clr_err=1 for one cycle -> underflow=0.
REQ-026 Stream 100 words with push and pop both held at num=8 -> num stays 8, output order is intact across pointer wraps, and no error flags set.
REQ-027 With num=5, flush=1 together with push=1 -> num=0, empty=1; assert reset mid-stream -> all outputs match REQ-017 before the next clk edge.
REQ-028 Run every scenario in both SYNC_FIFO_FWFT_EN modes -> out timing matches REQ-019 or REQ-020 respectively.
